// File: rtl/sync_fifo_flags.sv
// Single-clock first-word-fall-through FIFO with fill count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_flags #(
   parameter int DWIDTH   = 8,
   parameter int AWIDTH   = 3,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              wr,
   input  logic [DWIDTH-1:0] wdata,
   input  logic              rd,
   output logic [DWIDTH-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [AWIDTH:0]   count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err
);

   localparam int DEPTH = 2 ** AWIDTH;
   localparam logic [AWIDTH:0] DEPTH_C = DEPTH[AWIDTH:0];
   localparam logic [AWIDTH:0] AF_C    = AF_LEVEL[AWIDTH:0];
   localparam logic [AWIDTH:0] AE_C    = AE_LEVEL[AWIDTH:0];

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH-1:0] wptr;
   logic [AWIDTH-1:0] rptr;
   logic              wr_ok;
   logic              rd_ok;

   // Flags decode from the registered count only, so they never glitch on inputs.
   assign full         = (count == DEPTH_C);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   // Flush suppresses both transfers; a full FIFO drops the write, an empty one the read.
   assign wr_ok = wr & ~full  & ~flush;
   assign rd_ok = rd & ~empty & ~flush;

   assign rdata = mem[rptr];

   // NOTE: storage has no reset so it maps onto plain RAM; rdata is don't-care while empty.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr] <= wdata;
   end

   // NOTE: non-blocking assignments keep every register updating from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_ok) wptr <= wptr + 1'b1;
         if (rd_ok) rptr <= rptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky errors: a new error in the same cycle as clr_err wins over the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr & full & ~flush)  overflow <= 1'b1;
         else if (clr_err)        overflow <= 1'b0;
         if (rd & empty & ~flush) underflow <= 1'b1;
         else if (clr_err)        underflow <= 1'b0;
      end
   end

endmodule
